// File: rtl/mem_stage.sv
// RV32 memory-access stage: issues aligned loads/stores on a req/gnt/rvalid bus and registers
// one result per instruction for writeback. Define MEM_BUS_TIMEOUT_EN to enable the bus timeout.
module mem_stage #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned RF_ADDR_WIDTH  = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ex_valid_i,
  output logic                     ex_ready_o,
  input  logic [1:0]               ex_mem_op_i,
  input  logic [2:0]               ex_funct3_i,
  input  logic [DATA_W-1:0]        ex_alu_result_i,
  input  logic [DATA_W-1:0]        ex_store_data_i,
  input  logic [RF_ADDR_WIDTH-1:0] ex_rd_addr_i,
  input  logic                     ex_rd_we_i,
  input  logic                     ex_exception_i,
  input  logic [3:0]               ex_cause_i,
  output logic                     dmem_req_o,
  output logic                     dmem_we_o,
  output logic [DATA_W-1:0]        dmem_addr_o,
  output logic [3:0]               dmem_be_o,
  output logic [DATA_W-1:0]        dmem_wdata_o,
  input  logic                     dmem_gnt_i,
  input  logic                     dmem_rvalid_i,
  input  logic [DATA_W-1:0]        dmem_rdata_i,
  input  logic                     dmem_err_i,
  input  logic                     wb_ready_i,
  output logic                     wb_rd_valid_o,
  output logic                     wb_rd_we_o,
  output logic [RF_ADDR_WIDTH-1:0] wb_rd_addr_o,
  output logic [DATA_W-1:0]        wb_rd_data_o,
  output logic                     wb_rd_exception_o,
  output logic [3:0]               wb_cause_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  localparam logic [3:0] CauseIllegal    = 4'd2;
  localparam logic [3:0] CauseLdMisalign = 4'd4;
  localparam logic [3:0] CauseLdFault    = 4'd5;
  localparam logic [3:0] CauseStMisalign = 4'd6;
  localparam logic [3:0] CauseStFault    = 4'd7;

  state_e                   state_q;
  logic [DATA_W-1:0]        addr_q;
  logic                     store_q;
  logic [2:0]               funct3_q;
  logic [RF_ADDR_WIDTH-1:0] rd_addr_q;
  logic                     rd_we_q;
  logic [3:0]               be_q;
  logic [DATA_W-1:0]        wdata_q;

  logic                     wb_valid_q;
  logic                     wb_we_q;
  logic [RF_ADDR_WIDTH-1:0] wb_addr_q;
  logic [DATA_W-1:0]        wb_data_q;
  logic                     wb_exc_q;
  logic [3:0]               wb_cause_q;

  logic                     is_load, is_store, is_mem, illegal, misaligned;
  logic                     accept, go_bus, imm_exc, imm_we, tmo_hit;
  logic [3:0]               imm_cause, dec_be;
  logic [DATA_W-1:0]        dec_wdata, lane, load_data;

  assign ex_ready_o = (state_q == StIdle) && (!wb_valid_q || wb_ready_i);
  assign accept     = ex_valid_i && ex_ready_o;

  always_comb begin
    is_load    = (ex_mem_op_i == 2'b01);
    is_store   = (ex_mem_op_i == 2'b10);
    is_mem     = is_load || is_store;
    illegal    = (ex_funct3_i == 3'b011) || (ex_funct3_i[2:1] == 2'b11) ||
                 (is_store && ex_funct3_i[2]);
    misaligned = ((ex_funct3_i[1:0] == 2'b01) && ex_alu_result_i[0]) ||
                 ((ex_funct3_i[1:0] == 2'b10) && (ex_alu_result_i[1:0] != 2'b00));
    imm_exc    = ex_exception_i || (is_mem && (illegal || misaligned));
    go_bus     = is_mem && !imm_exc;
    imm_we     = ex_rd_we_i && !is_store && (ex_rd_addr_i != '0) && !imm_exc;

    imm_cause = 4'd0;
    if (ex_exception_i)          imm_cause = ex_cause_i;
    else if (is_mem && illegal)  imm_cause = CauseIllegal;
    else if (is_mem && misaligned) begin
      imm_cause = is_store ? CauseStMisalign : CauseLdMisalign;
    end

    dec_be    = 4'b1111;
    dec_wdata = ex_store_data_i;
    unique case (ex_funct3_i[1:0])
      2'b00: begin
        dec_be    = 4'b0001 << ex_alu_result_i[1:0];
        dec_wdata = {(DATA_W/8){ex_store_data_i[7:0]}};
      end
      2'b01: begin
        dec_be    = 4'b0011 << {ex_alu_result_i[1], 1'b0};
        dec_wdata = {(DATA_W/16){ex_store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load formatting works off the latched address/funct3 of the outstanding access.
  always_comb begin
    lane = dmem_rdata_i >> {addr_q[1:0], 3'b000};
    unique case (funct3_q[1:0])
      2'b00:   load_data = {{(DATA_W-8){~funct3_q[2] & lane[7]}}, lane[7:0]};
      2'b01:   load_data = {{(DATA_W-16){~funct3_q[2] & lane[15]}}, lane[15:0]};
      default: load_data = dmem_rdata_i;
    endcase
  end

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CntW-1:0] tmo_cnt_q;

  // Counts only while stalled in REQ/WAIT, so every entry to either state starts from zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == StReq && !dmem_gnt_i) || (state_q == StWait && !dmem_rvalid_i)) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign tmo_hit = (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      store_q    <= 1'b0;
      funct3_q   <= '0;
      rd_addr_q  <= '0;
      rd_we_q    <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_exc_q   <= 1'b0;
      wb_cause_q <= '0;
    end else begin
      if (wb_valid_q && wb_ready_i) wb_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept && go_bus) begin
            addr_q    <= ex_alu_result_i;
            store_q   <= is_store;
            funct3_q  <= ex_funct3_i;
            rd_addr_q <= ex_rd_addr_i;
            rd_we_q   <= ex_rd_we_i && !is_store && (ex_rd_addr_i != '0);
            be_q      <= dec_be;
            wdata_q   <= dec_wdata;
            state_q   <= StReq;
          end else if (accept) begin
            wb_valid_q <= 1'b1;
            wb_we_q    <= imm_we;
            wb_addr_q  <= ex_rd_addr_i;
            wb_data_q  <= ex_alu_result_i;
            wb_exc_q   <= imm_exc;
            wb_cause_q <= imm_cause;
          end
        end
        StReq, StWait: begin
          if (state_q == StReq && dmem_gnt_i) begin
            state_q <= StWait;
          end else if ((state_q == StWait && dmem_rvalid_i) || tmo_hit) begin
            // A timeout is reported exactly like a bus error on the response.
            wb_valid_q <= 1'b1;
            wb_addr_q  <= rd_addr_q;
            if ((state_q == StWait && dmem_rvalid_i) && !dmem_err_i) begin
              wb_we_q    <= rd_we_q;
              wb_data_q  <= store_q ? addr_q : load_data;
              wb_exc_q   <= 1'b0;
              wb_cause_q <= 4'd0;
            end else begin
              wb_we_q    <= 1'b0;
              wb_data_q  <= addr_q;
              wb_exc_q   <= 1'b1;
              wb_cause_q <= store_q ? CauseStFault : CauseLdFault;
            end
            state_q <= StResp;
          end
        end
        StResp: begin
          if (wb_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dmem_req_o        = (state_q == StReq);
  assign dmem_we_o         = store_q;
  assign dmem_addr_o       = {addr_q[DATA_W-1:2], 2'b00};
  assign dmem_be_o         = be_q;
  assign dmem_wdata_o      = wdata_q;
  assign wb_rd_valid_o     = wb_valid_q;
  assign wb_rd_we_o        = wb_we_q;
  assign wb_rd_addr_o      = wb_addr_q;
  assign wb_rd_data_o      = wb_data_q;
  assign wb_rd_exception_o = wb_exc_q;
  assign wb_cause_o        = wb_cause_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single-instruction vectors plus hand-written
// sequences for stalls, back-to-back issue, reset mid-access and (if enabled) bus timeout.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_rd_we, ex_exc;
  logic [1:0]  ex_mem_op;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu, ex_sd;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_cause;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid, dmem_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_ready, wb_valid, wb_we, wb_exc;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  wb_cause;

  always #5 clk = ~clk;

  mem_stage #(
    .DATA_W        (32),
    .RF_ADDR_WIDTH (5),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ex_valid_i       (ex_valid),
    .ex_ready_o       (ex_ready),
    .ex_mem_op_i      (ex_mem_op),
    .ex_funct3_i      (ex_funct3),
    .ex_alu_result_i  (ex_alu),
    .ex_store_data_i  (ex_sd),
    .ex_rd_addr_i     (ex_rd),
    .ex_rd_we_i       (ex_rd_we),
    .ex_exception_i   (ex_exc),
    .ex_cause_i       (ex_cause),
    .dmem_req_o       (dmem_req),
    .dmem_we_o        (dmem_we),
    .dmem_addr_o      (dmem_addr),
    .dmem_be_o        (dmem_be),
    .dmem_wdata_o     (dmem_wdata),
    .dmem_gnt_i       (dmem_gnt),
    .dmem_rvalid_i    (dmem_rvalid),
    .dmem_rdata_i     (dmem_rdata),
    .dmem_err_i       (dmem_err),
    .wb_ready_i       (wb_ready),
    .wb_rd_valid_o    (wb_valid),
    .wb_rd_we_o       (wb_we),
    .wb_rd_addr_o     (wb_addr),
    .wb_rd_data_o     (wb_data),
    .wb_rd_exception_o(wb_exc),
    .wb_cause_o       (wb_cause)
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rd_we;
    logic        exc_in;
    logic [3:0]  cause_in;
    logic [31:0] rdata;
    logic        err;
    logic        bus;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] data;
    logic        exc;
    logic [3:0]  cause;
    logic        chk_data;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [4:0] rd, input logic rd_we);
    ex_valid  = 1'b1;
    ex_mem_op = op;
    ex_funct3 = f3;
    ex_alu    = alu;
    ex_sd     = sd;
    ex_rd     = rd;
    ex_rd_we  = rd_we;
    ex_exc    = 1'b0;
    ex_cause  = 4'd0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    @(negedge clk);
    drive(v.op, v.f3, v.addr, v.sd, v.rd, v.rd_we);
    ex_exc   = v.exc_in;
    ex_cause = v.cause_in;
    wb_ready = 1'b0;
    #1 check({t, " ex_ready"}, 32'(ex_ready), 32'd1);
    @(negedge clk);
    ex_valid = 1'b0;
    if (v.bus) begin
      check({t, " req"},   32'(dmem_req), 32'd1);
      check({t, " we"},    32'(dmem_we), 32'(v.op == 2'b10));
      check({t, " addr"},  dmem_addr, {v.addr[31:2], 2'b00});
      check({t, " be"},    32'(dmem_be), 32'(v.be));
      check({t, " wdata"}, dmem_wdata, v.wdata);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      check({t, " req after gnt"}, 32'(dmem_req), 32'd0);
      @(negedge clk);
      dmem_rvalid = 1'b1;
      dmem_rdata  = v.rdata;
      dmem_err    = v.err;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      dmem_err    = 1'b0;
      dmem_rdata  = '0;
    end else begin
      check({t, " no req"}, 32'(dmem_req), 32'd0);
    end
    check({t, " wb_valid"}, 32'(wb_valid), 32'd1);
    check({t, " wb_we"},    32'(wb_we), 32'(v.we));
    check({t, " wb_addr"},  32'(wb_addr), 32'(v.rd));
    check({t, " wb_exc"},   32'(wb_exc), 32'(v.exc));
    check({t, " wb_cause"}, 32'(wb_cause), 32'(v.cause));
    if (v.chk_data) check({t, " wb_data"}, wb_data, v.data);
    wb_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            op     f3      addr          sd            rd     we    exc   cin
    //            rdata         err   bus   be       wdata         rwe   data        exc  cause chk
    vecs.push_back(vec_t'{2'b00, 3'b000, 32'h1234_5678, 32'h0, 5'd3, 1'b1, 1'b0, 4'd0,
      32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 4'd0, 1'b1});
    vecs.push_back(vec_t'{2'b11, 3'b000, 32'hA5A5_A5A5, 32'h0, 5'd0, 1'b1, 1'b0, 4'd0,
      32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'hA5A5_A5A5, 1'b0, 4'd0, 1'b1});
    vecs.push_back(vec_t'{2'b01, 3'b010, 32'h0000_0400, 32'h0, 5'd9, 1'b1, 1'b1, 4'd3,
      32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0000_0400, 1'b1, 4'd3, 1'b1});
    vecs.push_back(vec_t'{2'b01, 3'b010, 32'h0000_0100, 32'h0, 5'd5, 1'b1, 1'b0, 4'd0,
      32'hDEAD_BEEF, 1'b0, 1'b1, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 4'd0, 1'b1});
    vecs.push_back(vec_t'{2'b01, 3'b000, 32'h0000_0203, 32'h0, 5'd6, 1'b1, 1'b0, 4'd0,
      32'h80FF_FF7F, 1'b0, 1'b1, 4'h8, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0, 4'd0, 1'b1});
    vecs.push_back(vec_t'{2'b01, 3'b100, 32'h0000_0203, 32'h0, 5'd6, 1'b1, 1'b0, 4'd0,
      32'h80FF_FF7F, 1'b0, 1'b1, 4'h8, 32'h0, 1'b1, 32'h0000_0080, 1'b0, 4'd0, 1'b1});
    vecs.push_back(vec_t'{2'b01, 3'b001, 32'h0000_0202, 32'h0, 5'd7, 1'b1, 1'b0, 4'd0,
      32'h80FF_FF7F, 1'b0, 1'b1, 4'hC, 32'h0, 1'b1, 32'hFFFF_80FF, 1'b0, 4'd0, 1'b1});
    vecs.push_back(vec_t'{2'b01, 3'b101, 32'h0000_0200, 32'h0, 5'd7, 1'b1, 1'b0, 4'd0,
      32'h1234_F00D, 1'b0, 1'b1, 4'h3, 32'h0, 1'b1, 32'h0000_F00D, 1'b0, 4'd0, 1'b1});
    vecs.push_back(vec_t'{2'b10, 3'b001, 32'h0000_0302, 32'h0000_ABCD, 5'd7, 1'b1, 1'b0, 4'd0,
      32'h0, 1'b0, 1'b1, 4'hC, 32'hABCD_ABCD, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0});
    vecs.push_back(vec_t'{2'b10, 3'b000, 32'h0000_0001, 32'h1122_3344, 5'd1, 1'b1, 1'b0, 4'd0,
      32'h0, 1'b0, 1'b1, 4'h2, 32'h4444_4444, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0});
    vecs.push_back(vec_t'{2'b10, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 5'd1, 1'b0, 1'b0, 4'd0,
      32'h0, 1'b0, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0});
    vecs.push_back(vec_t'{2'b01, 3'b010, 32'h0000_0102, 32'h0, 5'd9, 1'b1, 1'b0, 4'd0,
      32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0000_0102, 1'b1, 4'd4, 1'b1});
    vecs.push_back(vec_t'{2'b10, 3'b010, 32'h0000_0101, 32'h5, 5'd9, 1'b0, 1'b0, 4'd0,
      32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0000_0101, 1'b1, 4'd6, 1'b1});
    vecs.push_back(vec_t'{2'b01, 3'b001, 32'h0000_0105, 32'h0, 5'd9, 1'b1, 1'b0, 4'd0,
      32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0000_0105, 1'b1, 4'd4, 1'b1});
    vecs.push_back(vec_t'{2'b01, 3'b011, 32'h0000_0100, 32'h0, 5'd9, 1'b1, 1'b0, 4'd0,
      32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0000_0100, 1'b1, 4'd2, 1'b1});
    vecs.push_back(vec_t'{2'b10, 3'b100, 32'h0000_0100, 32'h0, 5'd9, 1'b0, 1'b0, 4'd0,
      32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0000_0100, 1'b1, 4'd2, 1'b1});
    vecs.push_back(vec_t'{2'b01, 3'b010, 32'h0000_0040, 32'h0, 5'd8, 1'b1, 1'b0, 4'd0,
      32'h0, 1'b1, 1'b1, 4'hF, 32'h0, 1'b0, 32'h0000_0040, 1'b1, 4'd5, 1'b1});
    vecs.push_back(vec_t'{2'b10, 3'b010, 32'h0000_0044, 32'h99, 5'd8, 1'b0, 1'b0, 4'd0,
      32'h0, 1'b1, 1'b1, 4'hF, 32'h99, 1'b0, 32'h0000_0044, 1'b1, 4'd7, 1'b1});

    // Reset state.
    rst = 1'b1;
    ex_valid = 1'b0; ex_mem_op = '0; ex_funct3 = '0; ex_alu = '0; ex_sd = '0;
    ex_rd = '0; ex_rd_we = 1'b0; ex_exc = 1'b0; ex_cause = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; dmem_err = 1'b0;
    wb_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset wb_valid", 32'(wb_valid), 32'd0);
    check("reset req", 32'(dmem_req), 32'd0);
    check("reset wb_data", wb_data, 32'd0);
    check("reset wb_cause", 32'(wb_cause), 32'd0);
    check("reset be", 32'(dmem_be), 32'd0);
    rst = 1'b0;
    #1 check("reset ex_ready", 32'(ex_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Writeback stall for 3 cycles, then release with the next instruction accepted at once.
    @(negedge clk);
    drive(2'b00, 3'b000, 32'h55, 32'h0, 5'd4, 1'b1);
    wb_ready = 1'b0;
    @(negedge clk);
    drive(2'b00, 3'b000, 32'h66, 32'h0, 5'd6, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall%0d ex_ready", i), 32'(ex_ready), 32'd0);
      check($sformatf("stall%0d wb_valid", i), 32'(wb_valid), 32'd1);
      check($sformatf("stall%0d wb_data", i), wb_data, 32'h55);
      check($sformatf("stall%0d wb_addr", i), 32'(wb_addr), 32'd4);
      @(negedge clk);
    end
    wb_ready = 1'b1;
    #1 check("release ex_ready", 32'(ex_ready), 32'd1);
    @(negedge clk);
    check("b2b first data", wb_data, 32'h66);
    check("b2b first addr", 32'(wb_addr), 32'd6);
    check("b2b first valid", 32'(wb_valid), 32'd1);
    drive(2'b00, 3'b000, 32'h77, 32'h0, 5'd7, 1'b1);
    @(negedge clk);
    check("b2b second data", wb_data, 32'h77);
    drive(2'b00, 3'b000, 32'h88, 32'h0, 5'd0, 1'b1);
    @(negedge clk);
    check("b2b third data", wb_data, 32'h88);
    check("b2b third we rd0", 32'(wb_we), 32'd0);
    ex_valid = 1'b0;
    @(negedge clk);
    check("drain wb_valid", 32'(wb_valid), 32'd0);

    // Delayed grant keeps the request stable; reset during WAIT abandons the access.
    drive(2'b01, 3'b010, 32'h0000_0080, 32'h0, 5'd2, 1'b1);
    @(negedge clk);
    ex_valid = 1'b0;
    check("nognt req0", 32'(dmem_req), 32'd1);
    check("nognt addr0", dmem_addr, 32'h80);
    @(negedge clk);
    check("nognt req1", 32'(dmem_req), 32'd1);
    check("nognt addr1", dmem_addr, 32'h80);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check("wait req", 32'(dmem_req), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst wait req", 32'(dmem_req), 32'd0);
    check("rst wait wb_valid", 32'(wb_valid), 32'd0);
    #1 check("rst wait ex_ready", 32'(ex_ready), 32'd1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("stray rvalid wb_valid", 32'(wb_valid), 32'd0);
    check("stray rvalid ex_ready", 32'(ex_ready), 32'd1);

`ifdef MEM_BUS_TIMEOUT_EN
    drive(2'b01, 3'b010, 32'h0000_0500, 32'h0, 5'd3, 1'b1);
    wb_ready = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0;
    repeat (63) @(negedge clk);
    check("tmo req held", 32'(dmem_req), 32'd1);
    @(negedge clk);
    check("tmo req dropped", 32'(dmem_req), 32'd0);
    check("tmo wb_valid", 32'(wb_valid), 32'd1);
    check("tmo wb_exc", 32'(wb_exc), 32'd1);
    check("tmo wb_cause", 32'(wb_cause), 32'd5);
    check("tmo wb_data", wb_data, 32'h500);
    wb_ready = 1'b1;
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- RV32 memory-access stage between execute and writeback.
- Issues aligned loads/stores on a req/gnt/rvalid data bus.
- Formats load data with byte/half extraction and sign/zero extension.
- Detects misaligned and bus-error faults; presents one registered result per instruction (rd_addr, rd_data, rd_valid, rd_exception) to the writeback stage.

Parameters:
- DATA_W, 32, data/address width (RV32 only).
- RF_ADDR_WIDTH, 5, register-file address width.
- TIMEOUT_CYCLES, 64, bus wait limit; used only with MEM_BUS_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- ex_valid_i  in  1  execute result valid.
- ex_ready_o  out  1  stage can accept.
- ex_mem_op_i  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none).
- ex_funct3_i  in  3  access size/sign.
- ex_alu_result_i  in  DATA_W  effective address or ALU result.
- ex_store_data_i  in  DATA_W  rs2 value.
- ex_rd_addr_i  in  RF_ADDR_WIDTH  destination register.
- ex_rd_we_i  in  1  instruction writes rd.
- ex_exception_i  in  1  upstream exception.
- ex_cause_i  in  4  upstream cause.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  write.
- dmem_addr_o  out  DATA_W  word-aligned address ({addr[31:2],2'b00}).
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  DATA_W  lane-replicated store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  response valid.
- dmem_rdata_i  in  DATA_W  load data.
- dmem_err_i  in  1  bus error, qualified by rvalid.
- wb_ready_i  in  1  writeback accepts.
- wb_rd_valid_o  out  1  result valid.
- wb_rd_we_o  out  1  write rd.
- wb_rd_addr_o  out  RF_ADDR_WIDTH  destination.
- wb_rd_data_o  out  DATA_W  result; faulting address on exception.
- wb_rd_exception_o  out  1  exception.
- wb_cause_o  out  4  mcause code.

Behaviour:
- Reset: state IDLE; every output 0 except ex_ready_o, which is 1 in the first cycle after reset.
- Reset mid-transaction drops dmem_req_o and discards any in-flight response. A stray rvalid in IDLE is ignored.
- Handshake: ex_ready_o = (state==IDLE) && (!wb_rd_valid_o || wb_ready_i). An instruction transfers when ex_valid_i && ex_ready_o.
- Output register: holds all wb_* outputs until wb_ready_i is 1 while wb_rd_valid_o is 1. On that handshake, wb_rd_valid_o drops to 0 unless a new result is loaded in the same cycle.
- States:
  - IDLE: accepts a new instruction.
  - REQ: dmem_req_o=1, with addr/we/be/wdata stable until gnt.
  - WAIT: awaits rvalid.
  - RESP: result registered; waits for wb_ready_i, then returns to IDLE.
- Bus ordering: rvalid arrives no earlier than the cycle after gnt. gnt in REQ moves the FSM to WAIT the next cycle.
- Non-memory op: registered to output 1 cycle after accept (latency 1). rd_data = alu_result.
- Upstream exception: no bus access. Output: exception=1, cause=ex_cause_i, data=alu_result.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0. No bus access; output the next cycle.
  - Cause 4 for a load, 6 for a store; data = address.
- Illegal funct3 (011, 110, 111; also 100 and 101 on a store): cause 2, no bus access.
- funct3 encodings: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<{addr[1],1'b0}.
  - Word: 4'b1111.
- Store wdata: byte replicated ×4, half replicated ×2, word as-is.
- Load: select lane by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend.
- rvalid with err=1 gives cause 5 (load) or 7 (store), with data = address.
- Stores complete on rvalid with wb_rd_we_o=0.
- wb_rd_we_o = ex_rd_we_i && mem_op!=store && rd_addr!=0 && !exception.
- Back-to-back: the next instruction can be accepted in the cycle the output handshake completes. This gives 1 instruction per cycle for non-memory ops when wb_ready_i is held at 1.

Optional Feature:
- MEM_BUS_TIMEOUT_EN defined: a counter runs in REQ/WAIT and clears on state entry.
  - When it reaches TIMEOUT_CYCLES-1 without gnt/rvalid, the FSM goes to RESP with access-fault cause 5/7 and drops dmem_req_o.
  - A later stale rvalid is ignored.
- Undefined: no counter; the stage waits indefinitely.

Test Plan:
- LW at 0x100, gnt same cycle as req, rvalid 2 cycles later with 0xDEADBEEF, rd=5 -> wb_rd_data=0xDEADBEEF, we=1, addr=5, exception=0.
- LB at 0x203 with rdata 0x80FF_FF7F -> lane 3 gives 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x302 with rs2=0x0000ABCD -> be=4'b1100, wdata=0xABCDABCD, addr=0x300. Result has we=0.
- LW at 0x102 -> no dmem_req_o, exception=1, cause=4, data=0x102. SW at 0x101 -> cause=6.
- Hold wb_ready_i=0 for 3 cycles after a result -> outputs stable, ex_ready_o=0. Release -> next instruction accepted the same cycle.
- LW with rvalid+err -> cause=5. Assert rst_i during WAIT -> req=0, IDLE. With MEM_BUS_TIMEOUT_EN and no gnt for 64 cycles -> cause=5.
